bp_fe_queue_pair_sender: RTL and testbench

- Sits at the frontend end of the FE→BE queue interface, ahead of the dual-enqueue issue queue.
- Accepts at most one `bp_fe_queue_s` packet per cycle from fetch over valid/ready-and.
- Holds up to two packets and presents them on the dual port `fe_queue1/fe_queue2`, oldest in slot 1.
- Sends a lone packet on a non-fetch message, on a timeout, or when the pair cannot be formed; otherwise sends pairs.

---
 rtl/bp_fe_pkg.sv | 37 +++
 rtl/bp_fe_queue_pair_sender_timer.sv | 35 +++
 rtl/bp_fe_queue_pair_sender.sv | 106 ++++++++++
 tb/tb_bp_fe_queue_pair_sender.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// Shared frontend types and limits for the FE->BE queue path: the queue
// packet layout, the message kinds, and the bound on the pairing timeout.
package bp_fe_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef enum logic [1:0] {
    e_fe_fetch       = 2'd0,
    e_fe_exception   = 2'd1,
    e_fe_icache_miss = 2'd2,
    e_fe_itlb_miss   = 2'd3
  } bp_fe_msg_type_e;

  typedef struct packed {
    bp_fe_msg_type_e msg_type;
    logic [15:0]     pc;
    logic [15:0]     payload;
  } bp_fe_queue_s;

  localparam int bp_fe_queue_width_gp = $bits(bp_fe_queue_s);
  localparam int bp_fe_timeout_max_lp = 15;

  // Every configuration currently shares one packet layout.
  function automatic int bp_fe_queue_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return bp_fe_queue_width_gp;
      default:          return bp_fe_queue_width_gp;
    endcase
  endfunction

  function automatic logic is_fetch(input bp_fe_queue_s pkt);
    return (pkt.msg_type == e_fe_fetch);
  endfunction

endpackage

// File: rtl/bp_fe_queue_pair_sender_timer.sv
// Saturating idle counter used to release a lone fetch that never found a
// partner. Out-of-range timeouts are clamped to the supported maximum.
module bp_fe_pair_timer
  import bp_fe_pkg::*;
#(
  parameter int timeout_p = 4,
  localparam int sat_lp   = (timeout_p > bp_fe_timeout_max_lp) ? bp_fe_timeout_max_lp : timeout_p,
  localparam int width_lp = $clog2(sat_lp + 1)
)(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  output logic o_expired
);

  localparam logic [width_lp-1:0] sat_c_lp = width_lp'(sat_lp);

  logic [width_lp-1:0] r_count;

  // Count idle cycles, hold at the limit, restart on any clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (r_count != sat_c_lp) begin
      r_count <= r_count + {{(width_lp-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == sat_c_lp);

endmodule

// File: rtl/bp_fe_queue_pair_sender.sv
// Two-slot staging buffer between fetch and the dual-enqueue issue queue:
// pairs consecutive fetches, sends non-fetch messages and timed-out fetches alone.
module bp_fe_queue_pair_sender
  import bp_fe_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int timeout_p           = 4,
  localparam int fe_queue_width_lp  = bp_fe_queue_width(bp_params_p)
)(
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         clr_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_and_o,
  output logic [fe_queue_width_lp-1:0] fe_queue1_o,
  output logic [fe_queue_width_lp-1:0] fe_queue2_o,
  output logic                         fe_queue_v1_o,
  output logic                         fe_queue_v2_o,
  input  logic                         fe_queue_ready_i
);

  bp_fe_queue_s r_s0, r_s1;
  bp_fe_queue_s w_s0_n, w_s1_n;
  logic [1:0]   r_count;
  logic [1:0]   w_pop, w_count_after_pop, w_count_n;
  logic         w_expired, w_send_pair, w_send_single, w_fire;
  logic         w_ready, w_accept, w_timer_clr;

  // A full pair of fetches goes together; anything else that may leave goes alone.
  always_comb begin
    w_send_pair   = 1'b0;
    w_send_single = 1'b0;
    if (!clr_i && (r_count == 2'd2) && is_fetch(r_s0) && is_fetch(r_s1)) begin
      w_send_pair = 1'b1;
    end else if (!clr_i && (r_count != 2'd0) &&
                 (!is_fetch(r_s0) || ((r_count == 2'd2) && !is_fetch(r_s1)) || w_expired)) begin
      w_send_single = 1'b1;
    end else begin
      w_send_pair   = 1'b0;
      w_send_single = 1'b0;
    end
  end

  assign w_fire            = (w_send_pair | w_send_single) & fe_queue_ready_i;
  assign w_pop             = w_fire ? (w_send_pair ? 2'd2 : 2'd1) : 2'd0;
  assign w_ready           = reset_n_i & ~clr_i & ((r_count != 2'd2) | w_fire);
  assign w_accept          = fe_queue_v_i & w_ready;
  assign w_count_after_pop = r_count - w_pop;
  assign w_count_n         = w_count_after_pop + {1'b0, w_accept};
  assign w_timer_clr       = w_accept | w_fire | clr_i | (r_count != 2'd1);

  // Shift the survivor down after a single pop, then land the new packet
  // in the lowest slot left free.
  always_comb begin
    w_s0_n = r_s0;
    w_s1_n = r_s1;
    if (w_pop == 2'd1) begin
      w_s0_n = r_s1;
    end else begin
      w_s0_n = r_s0;
    end
    if (w_accept) begin
      case (w_count_after_pop)
        2'd0:    w_s0_n = bp_fe_queue_s'(fe_queue_i);
        2'd1:    w_s1_n = bp_fe_queue_s'(fe_queue_i);
        default: w_s1_n = r_s1;
      endcase
    end else begin
      w_s1_n = r_s1;
    end
  end

  // Occupancy; a flush empties the buffer regardless of fire or accept.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= 2'd0;
    end else if (clr_i) begin
      r_count <= 2'd0;
    end else begin
      r_count <= w_count_n;
    end
  end

  // Slot payloads carry no reset; validity comes only from the occupancy count.
  always_ff @(posedge clk_i) begin
    r_s0 <= w_s0_n;
    r_s1 <= w_s1_n;
  end

  bp_fe_pair_timer #(
    .timeout_p (timeout_p)
  ) u_timer (
    .i_clk     (clk_i),
    .i_reset_n (reset_n_i),
    .i_clr     (w_timer_clr),
    .o_expired (w_expired)
  );

  assign fe_queue_ready_and_o = w_ready;
  assign fe_queue_v1_o        = w_send_pair | w_send_single;
  assign fe_queue_v2_o        = w_send_pair;
  assign fe_queue1_o          = r_s0;
  assign fe_queue2_o          = w_send_pair ? r_s1 : '0;

endmodule

// File: tb/tb_bp_fe_queue_pair_sender.sv
// Directed bench for the pair sender: accepted packets go into an in-order
// scoreboard and every send is checked against it.
module tb_bp_fe_queue_pair_sender;
  import bp_fe_pkg::*;

  localparam int w_lp = bp_fe_queue_width_gp;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            clr = 1'b0;
  logic            v_in = 1'b0;
  logic            be_rdy = 1'b0;
  logic [w_lp-1:0] q_in = '0;
  logic            rdy_o, v1, v2;
  logic [w_lp-1:0] fq1, fq2;

  bp_fe_queue_s sb[$];
  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  bp_fe_queue_pair_sender #(
    .bp_params_p (e_bp_default_cfg),
    .timeout_p   (4)
  ) dut (
    .clk_i                (clk),
    .reset_n_i            (reset_n),
    .clr_i                (clr),
    .fe_queue_i           (q_in),
    .fe_queue_v_i         (v_in),
    .fe_queue_ready_and_o (rdy_o),
    .fe_queue1_o          (fq1),
    .fe_queue2_o          (fq2),
    .fe_queue_v1_o        (v1),
    .fe_queue_v2_o        (v2),
    .fe_queue_ready_i     (be_rdy)
  );

  function automatic bp_fe_queue_s mk(input bp_fe_msg_type_e t, input logic [15:0] pc);
    bp_fe_queue_s p;
    p.msg_type = t;
    p.pc       = pc;
    p.payload  = ~pc;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input bp_fe_queue_s p, input logic rdy);
    v_in   = v;
    q_in   = p;
    be_rdy = rdy;
    #1;
  endtask

  // Score this cycle's send and accept, then advance one clock.
  task automatic step();
    bp_fe_queue_s e;
    chk("v2_implies_v1", {63'd0, v2 & ~v1}, 64'd0);
    if (v1 && be_rdy) begin
      chk("sb_has_slot1", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_slot1", fq1, e);
      end
      if (v2) begin
        chk("sb_has_slot2", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_slot2", fq2, e);
        end
      end else begin
        chk("slot2_zero_on_single", fq2, 64'd0);
      end
    end
    if (v_in && rdy_o) sb.push_back(bp_fe_queue_s'(q_in));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bp_fe_queue_s a, b, c, d, e, f, h, i, j, k, x;
    a = mk(e_fe_fetch, 16'h1000);
    b = mk(e_fe_fetch, 16'h1004);
    c = mk(e_fe_fetch, 16'h2000);
    d = mk(e_fe_fetch, 16'h3000);
    e = mk(e_fe_exception, 16'h3004);
    f = mk(e_fe_fetch, 16'h4000);
    h = mk(e_fe_fetch, 16'h5000);
    i = mk(e_fe_fetch, 16'h5004);
    j = mk(e_fe_fetch, 16'h6000);
    k = mk(e_fe_fetch, 16'h6004);
    x = mk(e_fe_icache_miss, 16'h7000);

    // Reset
    #2 reset_n = 1'b0;
    #1;
    chk("rst_v1", {63'd0, v1}, 64'd0);
    chk("rst_v2", {63'd0, v2}, 64'd0);
    chk("rst_ready", {63'd0, rdy_o}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", {63'd0, rdy_o}, 64'd1);
    chk("post_rst_v1", {63'd0, v1}, 64'd0);

    // Pairing
    drive(1'b1, a, 1'b1);
    chk("pair_ready_a", {63'd0, rdy_o}, 64'd1);
    step();
    drive(1'b1, b, 1'b1);
    chk("pair_t1_v1", {63'd0, v1}, 64'd0);
    step();
    drive(1'b0, x, 1'b1);
    chk("pair_t2_v1", {63'd0, v1}, 64'd1);
    chk("pair_t2_v2", {63'd0, v2}, 64'd1);
    chk("pair_t2_q1", fq1, a);
    chk("pair_t2_q2", fq2, b);
    step();
    chk("pair_t3_v1", {63'd0, v1}, 64'd0);
    chk("pair_t3_ready", {63'd0, rdy_o}, 64'd1);

    // Timeout of a lone fetch
    drive(1'b1, c, 1'b1);
    step();
    drive(1'b0, x, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      chk("tmo_wait_v1", {63'd0, v1}, 64'd0);
      step();
    end
    chk("tmo_v1", {63'd0, v1}, 64'd1);
    chk("tmo_v2", {63'd0, v2}, 64'd0);
    chk("tmo_q1", fq1, c);
    chk("tmo_q2", fq2, 64'd0);
    step();
    chk("tmo_after_v1", {63'd0, v1}, 64'd0);

    // Non-fetch splits the pair
    drive(1'b1, d, 1'b1);
    step();
    drive(1'b1, e, 1'b1);
    chk("split_t1_v1", {63'd0, v1}, 64'd0);
    step();
    drive(1'b0, x, 1'b1);
    chk("split_a_v1", {63'd0, v1}, 64'd1);
    chk("split_a_v2", {63'd0, v2}, 64'd0);
    chk("split_a_q1", fq1, d);
    step();
    chk("split_e_v1", {63'd0, v1}, 64'd1);
    chk("split_e_v2", {63'd0, v2}, 64'd0);
    chk("split_e_q1", fq1, e);
    step();
    chk("split_after_v1", {63'd0, v1}, 64'd0);

    // Backpressure: hold a pair, then release with a new packet arriving
    drive(1'b1, h, 1'b0);
    step();
    drive(1'b1, i, 1'b0);
    step();
    drive(1'b1, f, 1'b0);
    for (int n = 0; n < 10; n++) begin
      chk("bp_ready", {63'd0, rdy_o}, 64'd0);
      chk("bp_v1", {63'd0, v1}, 64'd1);
      chk("bp_v2", {63'd0, v2}, 64'd1);
      chk("bp_q1", fq1, h);
      chk("bp_q2", fq2, i);
      step();
    end
    drive(1'b1, f, 1'b1);
    chk("bp_release_ready", {63'd0, rdy_o}, 64'd1);
    step();
    drive(1'b0, x, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      chk("bp_c_wait_v1", {63'd0, v1}, 64'd0);
      step();
    end
    chk("bp_c_v1", {63'd0, v1}, 64'd1);
    chk("bp_c_q1", fq1, f);
    step();

    // Flush while a pair is about to send
    drive(1'b1, j, 1'b1);
    step();
    drive(1'b1, k, 1'b1);
    step();
    drive(1'b1, d, 1'b1);
    clr = 1'b1;
    #1;
    chk("clr_v1", {63'd0, v1}, 64'd0);
    chk("clr_v2", {63'd0, v2}, 64'd0);
    chk("clr_ready", {63'd0, rdy_o}, 64'd0);
    step();
    clr = 1'b0;
    sb.delete();
    drive(1'b0, x, 1'b1);
    for (int n = 0; n < 7; n++) begin
      chk("clr_no_stale_v1", {63'd0, v1}, 64'd0);
      step();
    end

    // Asynchronous reset with a full buffer
    drive(1'b1, h, 1'b0);
    step();
    drive(1'b1, i, 1'b0);
    step();
    drive(1'b0, x, 1'b0);
    chk("arst_pre_v2", {63'd0, v2}, 64'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_v1", {63'd0, v1}, 64'd0);
    chk("arst_v2", {63'd0, v2}, 64'd0);
    chk("arst_ready", {63'd0, rdy_o}, 64'd0);
    sb.delete();
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("arst_rel_ready", {63'd0, rdy_o}, 64'd1);
    chk("arst_rel_v1", {63'd0, v1}, 64'd0);
    drive(1'b1, a, 1'b1);
    step();
    drive(1'b1, b, 1'b1);
    step();
    drive(1'b0, x, 1'b1);
    chk("arst_pair_v2", {63'd0, v2}, 64'd1);
    chk("arst_pair_q1", fq1, a);
    chk("arst_pair_q2", fq2, b);
    step();
    chk("arst_pair_after_v1", {63'd0, v1}, 64'd0);
    step();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
